// File: rtl/vram_port_arbiter_pkg.sv
// Shared types for the VRAM port arbiter: read-return tags, arbiter FSM states
// and the word/strobe widths of the VRAM data bus.
package vram_arb_pkg;

   typedef enum logic [1:0] {
      TAG_NONE,
      TAG_AXI,
      TAG_VID
   } arb_tag_t;

   typedef enum logic [1:0] {
      IDLE,
      RD_WAIT,
      HOLD
   } arb_state_t;

   localparam int WORD_W = 32;
   localparam int STRB_W = 4;

   // One slot of the read-return pipe: who owns the read and whether the
   // address was valid (out-of-range reads return zero instead of BRAM data).
   typedef struct packed {
      arb_tag_t tag;
      logic     in_range;
   } tag_ent_t;

endpackage

// File: rtl/vram_port_arbiter_if.sv
// Bundles the AXI-side, video-side and BRAM-side signals of the VRAM arbiter.
// master = requesters + BRAM environment, slave = the arbiter itself.
interface vram_port_arbiter_if
   import vram_arb_pkg::*;
#(
   parameter int ADDR_W = 10
);
   logic                axi_req;
   logic                axi_we;
   logic [ADDR_W-1:0]   axi_addr;
   logic [WORD_W-1:0]   axi_wdata;
   logic [STRB_W-1:0]   axi_wstrb;
   logic                axi_ack;
   logic [WORD_W-1:0]   axi_rdata;
   logic                axi_rvalid;

   logic                vid_req;
   logic [ADDR_W-1:0]   vid_addr;
   logic [WORD_W-1:0]   vid_rdata;
   logic                vid_rvalid;
   logic                vid_drop;

   logic                bram_en;
   logic [STRB_W-1:0]   bram_we;
   logic [ADDR_W-1:0]   bram_addr;
   logic [WORD_W-1:0]   bram_din;
   logic [WORD_W-1:0]   bram_dout;

   modport master (
      output axi_req, axi_we, axi_addr, axi_wdata, axi_wstrb,
      input  axi_ack, axi_rdata, axi_rvalid,
      output vid_req, vid_addr,
      input  vid_rdata, vid_rvalid, vid_drop,
      input  bram_en, bram_we, bram_addr, bram_din,
      output bram_dout
   );

   modport slave (
      input  axi_req, axi_we, axi_addr, axi_wdata, axi_wstrb,
      output axi_ack, axi_rdata, axi_rvalid,
      input  vid_req, vid_addr,
      output vid_rdata, vid_rvalid, vid_drop,
      output bram_en, bram_we, bram_addr, bram_din,
      input  bram_dout
   );

endinterface

// File: rtl/vram_rd_tag_pipe.sv
// READ_LAT-deep shift register that follows each BRAM read so its data can be
// steered to the right requester when it emerges. Synchronous flush on rst.
module vram_rd_tag_pipe
   import vram_arb_pkg::*;
#(
   parameter int READ_LAT = 2
) (
   input  logic     clk,
   input  logic     rst,
   input  tag_ent_t push,
   output tag_ent_t pop
);

   tag_ent_t pipe_q [READ_LAT];
   tag_ent_t pipe_d [READ_LAT];

   always_comb begin
      pipe_d[0] = push;
      for (int i = 1; i < READ_LAT; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < READ_LAT; i++) begin
            pipe_q[i] <= '{tag: TAG_NONE, in_range: 1'b0};
         end
      end else begin
         pipe_q <= pipe_d;
      end
   end

   assign pop = pipe_q[READ_LAT-1];

endmodule

// File: rtl/vram_port_arbiter.sv
// Single-port VRAM arbiter: video fetch has priority, AXI accesses serialised.
// Optional starvation guard for AXI enabled by defining VRAM_ARB_STARVE_GUARD_EN.
module vram_port_arbiter
   import vram_arb_pkg::*;
#(
   parameter int ADDR_W   = 10,
   parameter int DEPTH    = 600,
   parameter int READ_LAT = 2,
   parameter int MAX_WAIT = 16
) (
   input  logic          axi_aclk,
   input  logic          reset,
   vram_port_arbiter_if.slave bus
);

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

   arb_state_t        state_q, state_d;
   tag_ent_t          push, pop;
   logic              vid_gnt, axi_gnt, guard_hit;
   logic              vid_ok, axi_ok;
   logic              axi_rv, vid_rv;
   logic [WORD_W-1:0] exit_data;
   logic [WORD_W-1:0] axi_rdata_q, axi_rdata_d;
   logic [WORD_W-1:0] vid_rdata_q, vid_rdata_d;

   assign vid_ok = ({1'b0, bus.vid_addr} < DEPTH_C);
   assign axi_ok = ({1'b0, bus.axi_addr} < DEPTH_C);

`ifdef VRAM_ARB_STARVE_GUARD_EN
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

   logic [WAIT_W-1:0] wait_q, wait_d;

   assign guard_hit = (wait_q == MAX_WAIT_C) && (state_q == IDLE);

   // Saturates so a threshold reached outside IDLE still fires once IDLE returns.
   always_comb begin
      wait_d = wait_q;
      if (axi_gnt) begin
         wait_d = '0;
      end else if (bus.axi_req && (wait_q != MAX_WAIT_C)) begin
         wait_d = wait_q + WAIT_W'(1);
      end
   end

   always_ff @(posedge axi_aclk) begin
      if (reset) begin
         wait_q <= '0;
      end else begin
         wait_q <= wait_d;
      end
   end
`else
   assign guard_hit = 1'b0;
`endif

   always_comb begin
      vid_gnt      = 1'b0;
      axi_gnt      = 1'b0;
      bus.vid_drop = 1'b0;
      if (!reset) begin
         if (bus.axi_req && guard_hit) begin
            axi_gnt      = 1'b1;
            bus.vid_drop = bus.vid_req;
         end else if (bus.vid_req) begin
            vid_gnt = 1'b1;
         end else if (bus.axi_req && (state_q == IDLE)) begin
            axi_gnt = 1'b1;
         end
      end
   end

   always_comb begin
      bus.bram_en   = 1'b0;
      bus.bram_we   = '0;
      bus.bram_addr = '0;
      bus.bram_din  = '0;
      bus.axi_ack   = axi_gnt;
      push          = '{tag: TAG_NONE, in_range: 1'b0};
      if (vid_gnt) begin
         bus.bram_en   = vid_ok;
         bus.bram_addr = bus.vid_addr;
         push          = '{tag: TAG_VID, in_range: vid_ok};
      end else if (axi_gnt) begin
         bus.bram_en   = axi_ok;
         bus.bram_addr = bus.axi_addr;
         if (bus.axi_we) begin
            bus.bram_we  = axi_ok ? bus.axi_wstrb : '0;
            bus.bram_din = bus.axi_wdata;
         end else begin
            push = '{tag: TAG_AXI, in_range: axi_ok};
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (axi_gnt) begin
               state_d = bus.axi_we ? HOLD : RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (pop.tag == TAG_AXI) begin
               state_d = HOLD;
            end
         end
         HOLD:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge axi_aclk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   vram_rd_tag_pipe #(
      .READ_LAT (READ_LAT)
   ) u_tag_pipe (
      .clk  (axi_aclk),
      .rst  (reset),
      .push (push),
      .pop  (pop)
   );

   // Read return: data is live on the exit cycle, then held until the next pulse.
   always_comb begin
      exit_data   = pop.in_range ? bus.bram_dout : '0;
      axi_rv      = !reset && (pop.tag == TAG_AXI);
      vid_rv      = !reset && (pop.tag == TAG_VID);
      axi_rdata_d = axi_rv ? exit_data : axi_rdata_q;
      vid_rdata_d = vid_rv ? exit_data : vid_rdata_q;
   end

   assign bus.axi_rvalid = axi_rv;
   assign bus.vid_rvalid = vid_rv;
   assign bus.axi_rdata  = reset ? '0 : axi_rdata_d;
   assign bus.vid_rdata  = reset ? '0 : vid_rdata_d;

   always_ff @(posedge axi_aclk) begin
      if (reset) begin
         axi_rdata_q <= '0;
         vid_rdata_q <= '0;
      end else begin
         axi_rdata_q <= axi_rdata_d;
         vid_rdata_q <= vid_rdata_d;
      end
   end

endmodule
